// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM states
//   fetch_entry_t : one buffered instruction {pc, instr}
package fetch_pkg;

    localparam int unsigned     XLEN             = 32;
    localparam int unsigned     INSTR_BYTES      = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    // Canonical addi x0,x0,0; used by downstream stages to form bubbles.
    localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO of fetched {pc, instr} entries.
//   clk, reset : clock, asynchronous active-high reset
//   push       : write push_data at the tail
//   pop        : drop the head entry
//   clear      : empty the FIFO; overrides push and pop
//   count      : current number of entries
//   head       : oldest entry (valid when count != 0)
module fetch_buf
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer/count update; clear wins over any same-cycle push or pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the fetch PC, issues in-order requests to a variable
// latency instruction memory, buffers responses and hands {InstrD, PCD,
// PCPlus4D} to decode over valid_d/ready_d. PCSrc/PCTarget redirects
// flush the buffer and drop responses still in flight.
//   clk, reset                     : clock, asynchronous active-high reset
//   imem_req/imem_addr/imem_gnt    : request channel
//   imem_rvalid/imem_rdata         : in-order response channel
//   PCSrc/PCTarget                 : redirect from execute
//   valid_d/ready_d                : decode handshake
//   InstrD/PCD/PCPlus4D            : decode payload
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic        valid_d,
    input  logic        ready_d,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    fetch_state_t     state_q, state_d;
    logic [31:0]      pc_f_q, pc_f_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic [CNT_W-1:0] buf_count;
    fetch_entry_t     buf_head;
    fetch_entry_t     buf_push_data;
    logic             buf_nonempty;
    logic             rv_ok;
    logic             credit_ok;
    logic             grant;
    logic             push;
    logic             pop;
    logic [31:0]      target;
    logic             unused_tgt_lsb;

    assign target         = {PCTarget[31:2], 2'b00};
    assign unused_tgt_lsb = ^PCTarget[1:0];

    // A response with nothing outstanding is a memory protocol error; drop it.
    assign rv_ok        = imem_rvalid && (outst_q != '0);
    // Requests in flight plus buffered entries never exceed the buffer size,
    // so every response is guaranteed a slot.
    assign credit_ok    = (SUM_W'(outst_q) + SUM_W'(buf_count)) < SUM_W'(BUF_DEPTH);
    assign buf_nonempty = (buf_count != '0);
    assign grant        = imem_req && imem_gnt;
    assign push         = rv_ok && (discard_q == '0) && !PCSrc;
    assign pop          = valid_d && ready_d;

    assign buf_push_data = '{pc: resp_pc_q, instr: imem_rdata};

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (buf_push_data),
        .pop       (pop),
        .clear     (PCSrc),
        .count     (buf_count),
        .head      (buf_head)
    );

    // PC, outstanding and discard bookkeeping; redirect overrides all.
    always_comb begin
        pc_f_d    = pc_f_q;
        resp_pc_d = resp_pc_q;
        discard_d = discard_q;
        outst_d   = outst_q + CNT_W'(grant) - CNT_W'(rv_ok);
        if (grant) begin
            pc_f_d = pc_f_q + XLEN'(INSTR_BYTES);
        end
        if (push) begin
            resp_pc_d = resp_pc_q + XLEN'(INSTR_BYTES);
        end
        if (PCSrc) begin
            pc_f_d    = target;
            resp_pc_d = target;
            discard_d = outst_q - CNT_W'(rv_ok);
        end else if (rv_ok && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f_q    <= RESET_PC;
            resp_pc_q <= RESET_PC;
            outst_q   <= '0;
            discard_q <= '0;
        end else begin
            pc_f_q    <= pc_f_d;
            resp_pc_q <= resp_pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; FLUSH holds one extra cycle once discard has drained.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = FETCH;
            FLUSH:   if (discard_q == '0) state_d = FETCH;
            default: state_d = IDLE;
        endcase
        if (PCSrc) begin
            state_d = (discard_d != '0) ? FLUSH : FETCH;
        end
    end

    // FSM / datapath outputs; payload reads as zero while the buffer is empty.
    always_comb begin
        imem_req  = (state_q == FETCH) && !PCSrc && credit_ok;
        imem_addr = pc_f_q;
        valid_d   = buf_nonempty && !PCSrc;
        InstrD    = '0;
        PCD       = '0;
        PCPlus4D  = '0;
        if (buf_nonempty) begin
            InstrD   = buf_head.instr;
            PCD      = buf_head.pc;
            PCPlus4D = buf_head.pc + XLEN'(INSTR_BYTES);
        end
    end

    a_no_orphan_rvalid: assert property (
        @(posedge clk) disable iff (reset) imem_rvalid |-> (outst_q != '0)
    );

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        valid_d;
    logic        ready_d;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;

    instr_fetch #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .PCSrc       (PCSrc),
        .PCTarget    (PCTarget),
        .valid_d     (valid_d),
        .ready_d     (ready_d),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    // Reference model: memory in-flight queue, delivered-instruction queue,
    // next fetch address and number of stale responses still to come back.
    req_t         inflight[$];
    fetch_entry_t mbuf[$];
    logic [31:0]  m_pc;
    int           m_stale;
    bit           m_flush;
    int           last_due;
    int           cyc;
    int           first_valid;

    int p_gnt, p_ready, p_pcsrc, lat_lo, lat_hi;
    int n_tests = 0;
    int n_fail  = 0;

    bit          obs_valid;
    logic [31:0] obs_pcd;
    bit          obs_req;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h0000_0013;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    // mode: 0 random redirect, 1 forced redirect, 2 no redirect, 3 redirect iff response.
    task automatic step(input int mode, input logic [31:0] tgt);
        bit           rv, ps, exp_req, grant;
        logic [31:0]  t;
        fetch_entry_t e;
        int           due;
        @(posedge clk);
        #1;
        cyc++;
        rv          = (inflight.size() > 0) && (inflight[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(inflight[0].addr) : 32'hDEAD_BEEF;
        imem_gnt    = ($urandom_range(99) < p_gnt);
        ready_d     = ($urandom_range(99) < p_ready);
        case (mode)
            0:       ps = ($urandom_range(99) < p_pcsrc);
            1:       ps = 1'b1;
            2:       ps = 1'b0;
            default: ps = rv;
        endcase
        t        = (mode == 0) ? $urandom() : tgt;
        PCSrc    = ps;
        PCTarget = t;
        #1;
        exp_req = !m_flush && !ps && ((inflight.size() + mbuf.size()) < 2);
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        chk("valid_d", 32'(valid_d), 32'((mbuf.size() > 0) && !ps));
        if (mbuf.size() > 0) begin
            chk("PCD", PCD, mbuf[0].pc);
            chk("InstrD", InstrD, mbuf[0].instr);
            chk("PCPlus4D", PCPlus4D, mbuf[0].pc + 32'd4);
        end
        obs_valid = valid_d;
        obs_pcd   = PCD;
        obs_req   = imem_req;
        if (valid_d && first_valid < 0) first_valid = cyc;

        grant = exp_req && imem_gnt;
        if (ps) begin
            m_stale = inflight.size() - (rv ? 1 : 0);
            if (rv) void'(inflight.pop_front());
            mbuf.delete();
            m_pc    = {t[31:2], 2'b00};
            m_flush = (m_stale > 0);
        end else begin
            if (m_flush && m_stale == 0) m_flush = 1'b0;
            if (mbuf.size() > 0 && ready_d) void'(mbuf.pop_front());
            if (rv) begin
                e.pc    = inflight[0].addr;
                e.instr = mem_word(inflight[0].addr);
                void'(inflight.pop_front());
                if (m_stale > 0) m_stale--;
                else mbuf.push_back(e);
            end
            if (grant) begin
                due = cyc + int'($urandom_range(lat_hi, lat_lo));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                inflight.push_back('{addr: m_pc, due: due});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset();
        #1;
        reset       = 1'b1;
        PCSrc       = 1'b0;
        PCTarget    = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        imem_gnt    = 1'b0;
        ready_d     = 1'b0;
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_valid_d", 32'(valid_d), 32'd0);
        chk("rst_InstrD", InstrD, 32'd0);
        chk("rst_PCD", PCD, 32'd0);
        chk("rst_PCPlus4D", PCPlus4D, 32'd0);
        inflight.delete();
        mbuf.delete();
        m_pc        = 32'h0000_0000;
        m_stale     = 0;
        m_flush     = 1'b0;
        last_due    = 0;
        cyc         = 0;
        first_valid = -1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("idle_imem_req", 32'(imem_req), 32'd0);
    endtask

    task automatic wait_outstanding(input string tag, input int n);
        int k = 0;
        while (inflight.size() < n && k < 20) begin
            step(2, '0);
            k++;
        end
        chk(tag, 32'(inflight.size()), 32'(n));
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
        int k = 0;
        obs_valid = 1'b0;
        while (!obs_valid && k < 40) begin
            step(2, '0);
            k++;
        end
        chk(tag, obs_valid ? obs_pcd : 32'hBAD0_BAD0, exp_pc);
    endtask

    task automatic set_cfg(input int g, input int r, input int p, input int lo, input int hi);
        p_gnt = g; p_ready = r; p_pcsrc = p; lat_lo = lo; lat_hi = hi;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        set_cfg(100, 100, 0, 1, 1);
        do_reset();

        // Latency 1, always ready: streaming from address 0.
        repeat (20) step(2, '0);
        chk("first_valid_cycle", 32'(first_valid), 32'd3);

        // Decode stall: buffer fills, requests stop, nothing lost on release.
        p_ready = 0;
        repeat (10) step(2, '0);
        chk("stall_req_low", 32'(obs_req), 32'd0);
        chk("stall_valid_held", 32'(obs_valid), 32'd1);
        p_ready = 100;
        repeat (10) step(2, '0);

        // Latency 3, two outstanding, redirect to 0x100.
        set_cfg(100, 100, 0, 3, 3);
        wait_outstanding("two_outstanding_a", 2);
        step(1, 32'h0000_0100);
        wait_valid("redirect_0x100_pcd", 32'h0000_0100);

        // Redirect coinciding with a response and ready_d.
        set_cfg(100, 100, 0, 1, 1);
        repeat (5) step(2, '0);
        repeat (3) begin
            step(3, 32'h0000_0040);
            step(2, '0);
        end
        repeat (5) step(2, '0);

        // Misaligned target and wrap-around target.
        step(1, 32'h0000_0203);
        wait_valid("misaligned_target_pcd", 32'h0000_0200);
        step(1, 32'hFFFF_FFFC);
        wait_valid("wrap_target_pcd", 32'hFFFF_FFFC);
        wait_valid("wrap_next_pcd", 32'h0000_0000);

        // Reset in the middle of a flush with two outstanding.
        set_cfg(100, 100, 0, 3, 3);
        repeat (4) step(2, '0);
        wait_outstanding("two_outstanding_b", 2);
        step(1, 32'h0000_0300);
        step(2, '0);
        do_reset();
        wait_valid("post_reset_pcd", 32'h0000_0000);

        // Randomised traffic with redirects, stalls and variable latency.
        set_cfg(70, 70, 4, 1, 4);
        repeat (3000) step(0, '0);
        set_cfg(40, 30, 10, 1, 6);
        repeat (1500) step(0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the decode/controller stage.
- Maintains the fetch PC and issues in-order requests to an instruction memory with variable latency.
- Buffers returned instructions and presents {InstrD, PCD, PCPlus4D} to decode over a valid/ready handshake. The controller takes its op/funct3/funct7b5 fields from InstrD.
- Applies PCSrc/PCTarget redirects from execute and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- BUF_DEPTH, 2, instruction buffer entries; also the cap on outstanding requests plus buffered entries.

Ports:
- clk  input  1  single clock; rising edge.
- reset  input  1  asynchronous, active-high.
- imem_req  output  1  request valid.
- imem_addr  output  32  request byte address; always word aligned.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response valid; responses return in order, one per granted request.
- imem_rdata  input  32  response instruction word.
- PCSrc  input  1  redirect pulse (taken branch or jump).
- PCTarget  input  32  redirect address.
- valid_d  output  1  InstrD/PCD/PCPlus4D valid.
- ready_d  input  1  decode accepts this cycle.
- InstrD  output  32  instruction to decode/controller.
- PCD  output  32  address of InstrD.
- PCPlus4D  output  32  PCD + 4.

Behaviour:
- Reset (asynchronous, active-high):
  - pc_f = RESET_PC, resp_pc = RESET_PC.
  - Buffer empty; outstanding = 0; discard = 0; state IDLE.
  - imem_req = 0, valid_d = 0. InstrD, PCD and PCPlus4D are 0.
  - Reset mid-transaction drops all in-flight responses. Memory-side cleanup is the memory's concern.
- States:
  - IDLE: one cycle after reset deasserts, then go to FETCH.
  - FETCH: normal operation.
  - FLUSH: a redirect is pending and stale responses are still outstanding.
- Request rule:
  - imem_req = (state == FETCH) && !PCSrc && (outstanding + buf_count < BUF_DEPTH).
  - This credit rule guarantees every response has a buffer slot.
  - imem_addr = pc_f.
  - When req && gnt: pc_f += 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0) and outstanding += 1.
  - imem_addr is held stable while req is high and gnt is low.
- Response (rvalid) handling:
  - outstanding -= 1.
  - If discard > 0: discard -= 1 and the data is dropped.
  - Otherwise push {resp_pc, imem_rdata} into the buffer and resp_pc += 4.
  - Grant and response in the same cycle net outstanding unchanged.
  - rvalid with outstanding == 0 is a protocol error: ignored, flagged by an assertion.
- Output:
  - valid_d = buffer non-empty && !PCSrc.
  - InstrD/PCD are the buffer head, combinational. PCPlus4D = PCD + 4.
  - Pop when valid_d && ready_d.
  - Zero-cycle bypass is not allowed: first-instruction latency is grant-to-rvalid plus 1 cycle.
  - With ready_d low the buffer fills, then imem_req drops. Head data is stable while valid_d && !ready_d.
- Redirect (PCSrc = 1) has top priority:
  - Buffer cleared; any pop or push that cycle is ignored.
  - pc_f = resp_pc = {PCTarget[31:2], 2'b00}; misaligned low bits are cleared.
  - discard = outstanding − (rvalid this cycle ? 1 : 0). The response arriving this cycle is also dropped.
  - Go to FLUSH if the new discard > 0, else FETCH.
- FLUSH: no requests. Return to FETCH the cycle after discard reaches 0.
- Back-to-back redirects, or a redirect during FLUSH, recompute discard by the same rule. The last target wins.
- Simultaneous PCSrc and ready_d: ready_d is ignored.

Decomposition:
- Shared package fetch_pkg:
  - RESET_PC default.
  - XLEN = 32.
  - INSTR_BYTES = 4.
  - fetch_state_t enum {IDLE, FETCH, FLUSH}.
  - NOP = 32'h0000_0013, used by downstream bubbles.
- One sub-module, fetch_buf:
  - BUF_DEPTH-entry synchronous FIFO of {pc, instr}.
  - Ports: push, pop, clear (clear has priority), count, head.
  - Same clk/reset.
- The top level holds the PC, counters and FSM.

Test Plan:
- Reset, RESET_PC = 0, memory latency 1, ready_d = 1 -> imem_addr 0x0, 0x4, 0x8…; first valid_d at cycle 3 with PCD = 0, PCPlus4D = 4, InstrD matching memory; one instruction per cycle thereafter.
- Hold ready_d = 0 for 10 cycles -> valid_d held, PCD = 0x8 stable, imem_req low once outstanding + buf_count = 2; release -> 0x8, 0xC delivered in order with no loss or duplication.
- Latency 3 with 2 outstanding, PCSrc pulse, PCTarget = 0x100 -> both stale responses dropped; state FLUSH for 2 response cycles; next imem_addr = 0x100; next valid PCD = 0x100.
- PCSrc in the same cycle as rvalid and ready_d with 1 outstanding -> discard = 0, response dropped, pop ignored, valid_d = 0 that cycle, fetch resumes at target next cycle.
- PCTarget = 0x0000_0203 -> imem_addr 0x200; separately, PCTarget = 0xFFFF_FFFC -> next fetch address 0x0000_0000.
- Assert reset mid-FLUSH with 2 outstanding -> all outputs 0 immediately; fetch restarts at RESET_PC; stale rvalid after reset is ignored and the assertion fires.
